// File: rtl/regfile_2r1w_sb.sv
// regfile_2r1w_sb: 2-read/1-write register file with pending scoreboard, bypass and zero register
module regfile_2r1w_sb #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter bit ZERO_REG = 1,
  parameter bit BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic              rd_stall,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data_1,
  output logic [DATA_W-1:0] rd_data_2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [ADDR_W:0]   pending_cnt
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic wr_ok, rsv_ok, fwd_1, fwd_2, hz_1, hz_2, accept, inc, dec;
  always_comb begin
    wr_ok    = wr_en && !(ZERO_REG && wr_addr == '0);
    rsv_ok   = rsv_en && !(ZERO_REG && rsv_addr == '0);
    fwd_1    = BYPASS && wr_ok && wr_addr == rd_addr_1;
    fwd_2    = BYPASS && wr_ok && wr_addr == rd_addr_2;
    hz_1     = pend[rd_addr_1] && !fwd_1;
    hz_2     = pend[rd_addr_2] && !fwd_2;
    rd_stall = rd_en && (hz_1 || hz_2);
    accept   = rd_en && !rd_stall;
    inc      = rsv_ok && !pend[rsv_addr];
    // a same-cycle reservation of the written register keeps it pending
    dec      = wr_ok && pend[wr_addr] && !(rsv_ok && rsv_addr == wr_addr);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pend        <= '0;
      pending_cnt <= '0;
      rd_valid    <= 1'b0;
      rd_data_1   <= '0;
      rd_data_2   <= '0;
    end else begin
      if (wr_ok) begin
        regs[wr_addr] <= wr_data;
        pend[wr_addr] <= 1'b0;
      end
      if (rsv_ok) pend[rsv_addr] <= 1'b1;
      pending_cnt <= pending_cnt + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
      rd_valid    <= accept;
      if (accept) begin
        rd_data_1 <= fwd_1 ? wr_data : regs[rd_addr_1];
        rd_data_2 <= fwd_2 ? wr_data : regs[rd_addr_2];
      end
    end
  end
endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// tb_regfile_2r1w_sb: directed self-checking bench for regfile_2r1w_sb (default parameters)
module tb_regfile_2r1w_sb;
  logic        clk = 0, rst = 1;
  logic        rd_en = 0, wr_en = 0, rsv_en = 0;
  logic [4:0]  rd_addr_1 = 0, rd_addr_2 = 0, wr_addr = 0, rsv_addr = 0;
  logic [31:0] wr_data = 0;
  logic        rd_stall, rd_valid;
  logic [31:0] rd_data_1, rd_data_2;
  logic [5:0]  pending_cnt;
  int errors = 0, checks = 0;

  regfile_2r1w_sb dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .rd_stall(rd_stall), .rd_valid(rd_valid), .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) tick;
    rst = 0;
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_d1", rd_data_1, 0);
    chk("rst_d2", rd_data_2, 0);
    chk("rst_cnt", 32'(pending_cnt), 0);

    // basic write then read
    wr_en = 1; wr_addr = 3; wr_data = 32'hDEADBEEF;
    tick;
    wr_en = 0; rd_en = 1; rd_addr_1 = 3; rd_addr_2 = 0;
    #1 chk("basic_stall", 32'(rd_stall), 0);
    tick;
    chk("basic_valid", 32'(rd_valid), 1);
    chk("basic_d1", rd_data_1, 32'hDEADBEEF);
    chk("basic_d2", rd_data_2, 0);
    rd_en = 0; wr_en = 1; wr_addr = 0; wr_data = 32'h1234;
    tick;
    wr_en = 0; rd_en = 1; rd_addr_1 = 0; rd_addr_2 = 3;
    tick;
    chk("zero_d1", rd_data_1, 0);
    chk("zero_d2", rd_data_2, 32'hDEADBEEF);
    rd_en = 0;
    tick;
    chk("idle_valid", 32'(rd_valid), 0);
    chk("idle_hold", rd_data_2, 32'hDEADBEEF);

    // scoreboard stall, then cleared by a bypassed write
    rsv_en = 1; rsv_addr = 7;
    tick;
    rsv_en = 0;
    chk("rsv7_cnt", 32'(pending_cnt), 1);
    rd_en = 1; rd_addr_1 = 7; rd_addr_2 = 3;
    #1 chk("rsv7_stall", 32'(rd_stall), 1);
    tick;
    chk("stall_valid", 32'(rd_valid), 0);
    chk("stall_hold", rd_data_2, 32'hDEADBEEF);
    wr_en = 1; wr_addr = 7; wr_data = 32'h55;
    #1 chk("byp_stall", 32'(rd_stall), 0);
    tick;
    chk("byp_valid", 32'(rd_valid), 1);
    chk("byp_d1", rd_data_1, 32'h55);
    chk("byp_cnt", 32'(pending_cnt), 0);
    wr_en = 0; rd_en = 0;
    tick;

    // same-cycle reserve and write
    rsv_en = 1; rsv_addr = 9;
    tick;
    chk("r9_cnt", 32'(pending_cnt), 1);
    wr_en = 1; wr_addr = 9; wr_data = 32'hA;
    tick;
    wr_en = 0; rsv_en = 0;
    chk("rw9_cnt", 32'(pending_cnt), 1);
    rd_en = 1; rd_addr_1 = 9; rd_addr_2 = 0;
    #1 chk("rw9_stall", 32'(rd_stall), 1);
    rd_en = 0;

    // counter bounds
    rsv_en = 1;
    for (int i = 1; i < 32; i++) begin
      rsv_addr = 5'(i);
      tick;
    end
    chk("all_cnt", 32'(pending_cnt), 31);
    rsv_addr = 1;
    tick;
    chk("rersv_cnt", 32'(pending_cnt), 31);
    rsv_addr = 0;
    tick;
    chk("rsv0_cnt", 32'(pending_cnt), 31);
    rsv_en = 0; rd_en = 1; rd_addr_1 = 0; rd_addr_2 = 0;
    #1 chk("r0_nostall", 32'(rd_stall), 0);
    rd_en = 0; wr_en = 1;
    for (int i = 1; i < 32; i++) begin
      wr_addr = 5'(i); wr_data = 32'(i * 3);
      tick;
    end
    wr_en = 0;
    chk("drain_cnt", 32'(pending_cnt), 0);
    rd_en = 1; rd_addr_1 = 9; rd_addr_2 = 31;
    #1 chk("drain_stall", 32'(rd_stall), 0);
    tick;
    chk("drain_d1", rd_data_1, 27);
    chk("drain_d2", rd_data_2, 93);
    rd_en = 0;

    // dual-port same address with bypass
    wr_en = 1; wr_addr = 4; wr_data = 32'h10;
    tick;
    wr_data = 32'h20; rd_en = 1; rd_addr_1 = 4; rd_addr_2 = 4;
    tick;
    wr_en = 0; rd_en = 0;
    chk("dual_d1", rd_data_1, 32'h20);
    chk("dual_d2", rd_data_2, 32'h20);

    // asynchronous reset mid-run
    rsv_en = 1; rsv_addr = 5;
    tick;
    rsv_en = 0; rd_en = 1; rd_addr_1 = 3; rd_addr_2 = 4;
    tick;
    rd_en = 0;
    chk("pre_valid", 32'(rd_valid), 1);
    chk("pre_cnt", 32'(pending_cnt), 1);
    #2 rst = 1;
    #1;
    chk("arst_valid", 32'(rd_valid), 0);
    chk("arst_d1", rd_data_1, 0);
    chk("arst_d2", rd_data_2, 0);
    chk("arst_cnt", 32'(pending_cnt), 0);
    tick;
    rst = 0; rd_en = 1; rd_addr_1 = 5; rd_addr_2 = 3;
    #1 chk("post_stall", 32'(rd_stall), 0);
    tick;
    rd_en = 0;
    chk("post_valid", 32'(rd_valid), 1);
    chk("post_d1", rd_data_1, 0);
    chk("post_d2", rd_data_2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_2r1w_sb.md
Name: regfile_2r1w_sb

Overview:
Parametrised two-read/one-write register file for the datapath core, replacing the fixed two-entry byte-wide register block.
- Adds a per-register pending scoreboard with read-stall reporting, write-to-read bypass, and a hardwired zero register.
- Registered read with 1-cycle latency.
- Sits between the decode stage (reads/reservations) and the writeback stage (writes).

Parameters:
ADDR_W, 5, address width; depth = 2**ADDR_W registers
DATA_W, 32, data width of each register
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and reservations
BYPASS, 1, 1 = same-cycle write data forwarded to read ports and clears hazard

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
rd_en  in  1  read request for both ports
rd_addr_1  in  ADDR_W  read port 1 address
rd_addr_2  in  ADDR_W  read port 2 address
rd_stall  out  1  combinational; read request blocked by pending hazard this cycle
rd_valid  out  1  registered; rd_data_1/2 carry the result of a read accepted last cycle
rd_data_1  out  DATA_W  registered read data port 1
rd_data_2  out  DATA_W  registered read data port 2
wr_en  in  1  write strobe (writeback)
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rsv_en  in  1  reserve strobe: mark destination pending (decode issue)
rsv_addr  in  ADDR_W  register to reserve
pending_cnt  out  ADDR_W+1  registered count of pending registers

Behaviour:
- Reset (async, rst=1): all registers = 0, pending vector = 0, rd_data_1/2 = 0, rd_valid = 0, pending_cnt = 0. Applies mid-operation; in-flight read discarded.
- Zero register (ZERO_REG=1): address 0 reads 0, never pending; writes and reservations to 0 ignored.
- Write: wr_en=1 and the address is writable -> reg[wr_addr] <= wr_data at the edge; pend[wr_addr] <= 0 unless reserved the same cycle.
- Reserve: rsv_en=1, addr≠0 (or ZERO_REG=0) -> pend[rsv_addr] <= 1. Reserving an already-pending register leaves it pending. Single-producer tracking only.
- Reserve and write to the same address in the same cycle: data is written and pend ends 1, because the reservation is newer.
- Hazard per port n:
  - BYPASS=1: hz_n = pend[addr_n] && !(wr_en && wr_addr==addr_n).
  - BYPASS=0: hz_n = pend[addr_n].
  - Zero register never hazards.
- rd_stall = rd_en && (hz_1 || hz_2), combinational from current-cycle inputs.
- Read accept = rd_en && !rd_stall. On accept, next edge:
  - rd_data_n <= forwarded wr_data if BYPASS=1 && wr_en && wr_addr==addr_n (nonzero), else reg[addr_n] before this edge's write.
  - rd_valid <= 1.
- No accept: rd_valid <= 0, rd_data_1/2 hold their previous value.
- BYPASS=0 with same-cycle write to a non-pending read address: the old value is returned.
- Both ports may address the same register; both get identical data.
- pending_cnt always equals popcount of the pending vector after each edge. Updated incrementally:
  - +1 on reserve of a non-pending register.
  - −1 on write clearing a pending register.
  - Net 0 when a write and a reserve hit the same pending register.
  - Never exceeds 2**ADDR_W − ZERO_REG.
- Latency: read 1 cycle; write visible to a non-bypassed read the cycle after the write edge.

Test Plan:
- Reset mid-run: registers written, r5 pending, rd_valid=1; assert rst asynchronously -> immediately rd_data=0, rd_valid=0, pending_cnt=0. After release, read r5 -> 0, no stall.
- Basic write/read: write r3=0xDEADBEEF; next cycle rd_en, addr1=3, addr2=0 -> one cycle later rd_valid=1, rd_data_1=0xDEADBEEF, rd_data_2=0. Writing r0=0x1234 has no effect (reads 0).
- Scoreboard stall: reserve r7; next cycle rd_en, addr1=7 -> rd_stall=1, following cycle rd_valid=0 and rd_data held. Write r7=0x55 with rd_en held:
  - BYPASS=1: that cycle rd_stall=0, next rd_data_1=0x55.
  - BYPASS=0: stall that cycle, read accepted the cycle after.
- Same-cycle reserve+write: r9 pending, pending_cnt=1; wr r9=0xA and rsv r9 together -> r9=0xA, pend[9]=1, pending_cnt=1, reading r9 stalls.
- Counter bounds: reserve every register 1..2**ADDR_W−1, one per cycle (re-reserve r1 twice) -> pending_cnt=31 (ADDR_W=5). Write all back -> pending_cnt=0. Reserving r0 never changes the count.
- Dual-port same address with bypass: r4=0x10 not pending; in the same cycle wr r4=0x20, rd_en addr1=addr2=4 -> both rd_data=0x20 (BYPASS=1) or both 0x10 (BYPASS=0).
